// File: rtl/logic_op_pipe.sv
// Bitwise logic unit: eight ops, accumulator-as-B, one registered result stage.
// Define LOGIC_OP_PARITY_EN to add the registered parity output.
module logic_op_pipe #(
   parameter int               WIDTH    = 8,
   parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic             acc_sel,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             result_zero,
`ifdef LOGIC_OP_PARITY_EN
   output logic             parity,
`endif
   output logic [WIDTH-1:0] acc
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             zero_q, zero_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] opb;
   logic [WIDTH-1:0] calc;
   logic             accept;

   assign in_ready = ena & (~valid_q | out_ready);
   assign accept   = in_valid & in_ready;
   assign opb      = acc_sel ? acc_q : b;

   always_comb begin
      calc = '0;
      unique case (op)
         3'b000: calc = a & opb;
         3'b001: calc = a | opb;
         3'b010: calc = a ^ opb;
         3'b011: calc = ~(a & opb);
         3'b100: calc = ~(a | opb);
         3'b101: calc = ~(a ^ opb);
         3'b110: calc = a;
         3'b111: calc = ~a;
      endcase
   end

   always_comb begin
      valid_d = valid_q;
      res_d   = res_q;
      zero_d  = zero_q;
      if (accept) begin
         valid_d = 1'b1;
         res_d   = calc;
         zero_d  = (calc == '0);
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   // Clear takes priority over the accept-time update.
   always_comb begin
      acc_d = acc_q;
      if (acc_clr)
         acc_d = ACC_INIT;
      else if (accept)
         acc_d = calc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         res_q   <= '0;
         zero_q  <= 1'b1;
         acc_q   <= ACC_INIT;
      end else begin
         valid_q <= valid_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
         acc_q   <= acc_d;
      end
   end

`ifdef LOGIC_OP_PARITY_EN
   logic par_q, par_d;

   always_comb begin
      par_d = par_q;
      if (accept)
         par_d = ^calc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         par_q <= 1'b0;
      else
         par_q <= par_d;
   end

   assign parity = par_q;
`endif

   assign out_valid   = valid_q;
   assign result      = res_q;
   assign result_zero = zero_q;
   assign acc         = acc_q;

endmodule

// File: tb/tb_logic_op_pipe.sv
// Directed self-checking bench for logic_op_pipe (WIDTH=8, ACC_INIT=0).
// Parity checks are compiled in when LOGIC_OP_PARITY_EN is defined.
module tb_logic_op_pipe;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         ena;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [2:0]   op;
   logic         acc_sel;
   logic         acc_clr;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         result_zero;
   logic [W-1:0] acc;
`ifdef LOGIC_OP_PARITY_EN
   logic         parity;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   logic_op_pipe #(.WIDTH(W), .ACC_INIT(8'h00)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .op         (op),
      .acc_sel    (acc_sel),
      .acc_clr    (acc_clr),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .result_zero(result_zero),
`ifdef LOGIC_OP_PARITY_EN
      .parity     (parity),
`endif
      .acc        (acc)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0;
      a = '0; b = '0; op = '0; acc_sel = 1'b0;
      acc_clr = 1'b0; out_ready = 1'b1;
      #12;
      tests++;
      if (out_valid !== 1'b0) begin
         fails++; $display("FAIL reset_out_valid got %b want 0", out_valid);
      end
      tests++;
      if (result !== 8'h00) begin
         fails++; $display("FAIL reset_result got %h want 00", result);
      end
      tests++;
      if (result_zero !== 1'b1) begin
         fails++; $display("FAIL reset_zero got %b want 1", result_zero);
      end
      tests++;
      if (acc !== 8'h00) begin
         fails++; $display("FAIL reset_acc got %h want 00", acc);
      end
      tests++;
      if (in_ready !== 1'b1) begin
         fails++; $display("FAIL reset_in_ready_ena1 got %b want 1", in_ready);
      end
      ena = 1'b0;
      #1;
      tests++;
      if (in_ready !== 1'b0) begin
         fails++; $display("FAIL reset_in_ready_ena0 got %b want 0", in_ready);
      end
      ena = 1'b1;
`ifdef LOGIC_OP_PARITY_EN
      tests++;
      if (parity !== 1'b0) begin
         fails++; $display("FAIL reset_parity got %b want 0", parity);
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_ops();
      logic [W-1:0] exp [8];
      exp = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'hF0, 8'h0F};
      a = 8'hF0; b = 8'h3C; acc_sel = 1'b0;
      out_ready = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         op = 3'(i);
         tick();
         tests++;
         if (result !== exp[i] || out_valid !== 1'b1 || result_zero !== 1'b0) begin
            fails++;
            $display("FAIL op%0d got %h v%b z%b want %h v1 z0",
                     i, result, out_valid, result_zero, exp[i]);
         end
      end
      in_valid = 1'b0;
      tick();
      tests++;
      if (out_valid !== 1'b0 || acc !== 8'h0F) begin
         fails++;
         $display("FAIL ops_drain got v%b acc %h want v0 acc 0f", out_valid, acc);
      end
      a = 8'h0F; b = 8'hF0; op = 3'b000; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tests++;
      if (result !== 8'h00 || result_zero !== 1'b1) begin
         fails++;
         $display("FAIL zero_flag got %h z%b want 00 z1", result, result_zero);
      end
      tick();
   endtask

   task automatic test_acc_chain();
      logic [W-1:0] ins [3];
      logic [W-1:0] exp [3];
      ins = '{8'h01, 8'h02, 8'h04};
      exp = '{8'h01, 8'h03, 8'h07};
      acc_clr = 1'b1;
      tick();
      acc_clr = 1'b0;
      tests++;
      if (acc !== 8'h00) begin
         fails++; $display("FAIL acc_clr got %h want 00", acc);
      end
      b = 8'hFF; op = 3'b001; acc_sel = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a = ins[i];
         tick();
         tests++;
         if (result !== exp[i]) begin
            fails++;
            $display("FAIL chain%0d got %h want %h", i, result, exp[i]);
         end
      end
      in_valid = 1'b0; acc_sel = 1'b0;
      tests++;
      if (acc !== 8'h07) begin
         fails++; $display("FAIL chain_acc got %h want 07", acc);
      end
      tick();
   endtask

   task automatic test_stall();
      out_ready = 1'b0;
      a = 8'h12; b = 8'h34; op = 3'b010; in_valid = 1'b1;
      tick();
      a = 8'hAB; b = 8'h0F; op = 3'b000;
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (in_ready !== 1'b0 || result !== 8'h26 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL stall%0d got r%b %h v%b want r0 26 v1",
                     i, in_ready, result, out_valid);
         end
         tick();
      end
      out_ready = 1'b1;
      #1;
      tests++;
      if (in_ready !== 1'b1) begin
         fails++; $display("FAIL stall_release got %b want 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      tests++;
      if (result !== 8'h0B || out_valid !== 1'b1 || acc !== 8'h0B) begin
         fails++;
         $display("FAIL stall_next got %h v%b acc %h want 0b v1 0b",
                  result, out_valid, acc);
      end
      tick();
      tests++;
      if (out_valid !== 1'b0 || result !== 8'h0B) begin
         fails++;
         $display("FAIL stall_drain got v%b %h want v0 0b", out_valid, result);
      end
   endtask

   task automatic test_clr_accept();
      a = 8'h55; op = 3'b110; acc_sel = 1'b0; in_valid = 1'b1;
      tick();
      a = 8'hFF; op = 3'b010; acc_sel = 1'b1; acc_clr = 1'b1;
      tick();
      in_valid = 1'b0; acc_clr = 1'b0; acc_sel = 1'b0;
      tests++;
      if (result !== 8'hAA || acc !== 8'h00) begin
         fails++;
         $display("FAIL clr_accept got %h acc %h want aa acc 00", result, acc);
      end
      a = 8'h3C; op = 3'b110; in_valid = 1'b1;
      tick();
      ena = 1'b0; a = 8'hFF;
      #1;
      tests++;
      if (in_ready !== 1'b0) begin
         fails++; $display("FAIL ena0_ready got %b want 0", in_ready);
      end
      tick();
      tick();
      tests++;
      if (acc !== 8'h3C || out_valid !== 1'b0 || result !== 8'h3C) begin
         fails++;
         $display("FAIL ena0_hold got acc %h v%b %h want 3c v0 3c",
                  acc, out_valid, result);
      end
      in_valid = 1'b0; ena = 1'b1;
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      a = 8'h07; b = 8'h00; op = 3'b001; acc_sel = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tests++;
      if (result !== 8'h07 || out_valid !== 1'b1) begin
         fails++; $display("FAIL par_res got %h v%b want 07 v1", result, out_valid);
      end
`ifdef LOGIC_OP_PARITY_EN
      tests++;
      if (parity !== 1'b1) begin
         fails++; $display("FAIL parity got %b want 1", parity);
      end
`endif
      tick();
      rst_n = 1'b0;
      #1;
      tests++;
      if (out_valid !== 1'b0 || result !== 8'h00 || result_zero !== 1'b1 ||
          acc !== 8'h00) begin
         fails++;
         $display("FAIL mid_reset got v%b %h z%b acc %h want v0 00 z1 00",
                  out_valid, result, result_zero, acc);
      end
`ifdef LOGIC_OP_PARITY_EN
      tests++;
      if (parity !== 1'b0) begin
         fails++; $display("FAIL mid_reset_parity got %b want 0", parity);
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_ops();
      test_acc_chain();
      test_stall();
      test_clr_accept();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
